// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand/result widths, add/sub mode encodings and
// the datapath types used by the execution units.
package alu_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam int ALU_OP_WIDTH  = 16;
  localparam int ALU_RES_WIDTH = 32;

  typedef logic signed [ALU_OP_WIDTH-1:0]  alu_op_t;
  typedef logic signed [ALU_RES_WIDTH-1:0] alu_res_t;

  typedef struct packed {
    logic zero;
    logic negative;
    logic ovf16;
  } alu_flags_t;

endpackage

// File: rtl/rca_adder.sv
// Parameterised N-bit ripple-carry adder built from per-bit full-adder
// equations; the carry chain runs from bit 0 upward.
module rca_adder #(
  parameter int N = 17
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[N];

endmodule

// File: rtl/adder_subtractor.sv
// Registered signed add/sub execution unit: one-cycle latency, exact
// (WIDTH+1)-bit sum sign-extended to RES_WIDTH, plus zero/negative/ovf16 flags.
module adder_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH     = ALU_OP_WIDTH,
  parameter int RES_WIDTH = ALU_RES_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     op1,
  input  logic [WIDTH-1:0]     op2,
  input  logic                 mode,
  output logic [RES_WIDTH-1:0] result,
  output logic                 out_valid,
  output logic                 zero,
  output logic                 negative,
  output logic                 ovf16
);

  // One extra bit of headroom means neither add nor sub can ever wrap.
  localparam int SW = WIDTH + 1;

  logic [SW-1:0]        op1x;
  logic [SW-1:0]        op2x;
  logic [SW-1:0]        op2_eff;
  logic                 carry_in;
  logic [SW-1:0]        sum;
  logic                 cout_unused;
  logic [RES_WIDTH-1:0] res_next;
  alu_flags_t           flags_next;

  logic [RES_WIDTH-1:0] result_q;
  alu_flags_t           flags_q;
  logic                 valid_q;

  assign op1x = {op1[WIDTH-1], op1};
  assign op2x = {op2[WIDTH-1], op2};

  // Subtraction is op1 + ~op2 + 1: invert op2 and feed mode in as carry-in.
  assign op2_eff  = (mode == MODE_ADD) ? op2x : ~op2x;
  assign carry_in = (mode == MODE_SUB);

  rca_adder #(
    .N (SW)
  ) u_rca (
    .a    (op1x),
    .b    (op2_eff),
    .cin  (carry_in),
    .sum  (sum),
    .cout (cout_unused)
  );

  assign res_next            = RES_WIDTH'($signed(sum));
  assign flags_next.zero     = (res_next == '0);
  assign flags_next.negative = res_next[RES_WIDTH-1];
  assign flags_next.ovf16    = sum[WIDTH] ^ sum[WIDTH-1];

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      flags_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        result_q <= res_next;
        flags_q  <= flags_next;
      end
    end
  end

  assign result    = result_q;
  assign out_valid = valid_q;
  assign zero      = flags_q.zero;
  assign negative  = flags_q.negative;
  assign ovf16     = flags_q.ovf16;

  a_mode_known : assert property (
    @(posedge clk) disable iff (!rst_n) in_valid |-> !$isunknown(mode)
  );

endmodule

// File: tb/tb_adder_subtractor.sv
// Self-checking bench for adder_subtractor: integer reference model checked
// every cycle, hand-computed boundary vectors, reset and hold scenarios.
module tb_adder_subtractor;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  alu_op_t     op1 = '0;
  alu_op_t     op2 = '0;
  logic        mode = MODE_ADD;
  logic [31:0] result;
  logic        out_valid, zero, negative, ovf16;

  int total = 0;
  int bad   = 0;

  adder_subtractor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .op1       (op1),
    .op2       (op2),
    .mode      (mode),
    .result    (result),
    .out_valid (out_valid),
    .zero      (zero),
    .negative  (negative),
    .ovf16     (ovf16)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the accepted operands.
  int   m_res   = 0;
  logic m_valid = 1'b0;
  logic m_zero  = 1'b0;
  logic m_neg   = 1'b0;
  logic m_ovf   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_res = 0; m_valid = 1'b0; m_zero = 1'b0; m_neg = 1'b0; m_ovf = 1'b0;
    end else begin
      m_valid = in_valid;
      if (in_valid) begin
        m_res  = (mode == MODE_SUB) ? int'(op1) - int'(op2) : int'(op1) + int'(op2);
        m_zero = (m_res == 0);
        m_neg  = (m_res < 0);
        m_ovf  = (m_res > 32767) || (m_res < -32768);
      end
    end
  end

  // Outputs are always defined (reset zeros or held values), so compare every cycle.
  always @(negedge clk) begin
    check("cyc_result",    result,    m_res);
    check("cyc_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    check("cyc_zero",      {31'b0, zero},      {31'b0, m_zero});
    check("cyc_negative",  {31'b0, negative},  {31'b0, m_neg});
    check("cyc_ovf16",     {31'b0, ovf16},     {31'b0, m_ovf});
  end

  typedef struct {
    int          a;
    int          b;
    logic        m;
    logic [31:0] r;
    logic        z;
    logic        n;
    logic        o;
  } vec_t;

  vec_t lits [8];

  task automatic apply(input int a, input int b, input logic m);
    @(negedge clk);
    op1 = 16'(a);
    op2 = 16'(b);
    mode = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    lits[0] = '{5,      3,      1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
    lits[1] = '{3,      5,      1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0};
    lits[2] = '{32767,  1,      1'b0, 32'h0000_8000, 1'b0, 1'b0, 1'b1};
    lits[3] = '{-32768, 1,      1'b1, 32'hFFFF_7FFF, 1'b0, 1'b1, 1'b1};
    lits[4] = '{-32768, 32767,  1'b1, 32'hFFFF_0001, 1'b0, 1'b1, 1'b1};
    lits[5] = '{-32768, -32768, 1'b0, 32'hFFFF_0000, 1'b0, 1'b1, 1'b1};
    lits[6] = '{32767,  -32768, 1'b1, 32'h0000_FFFF, 1'b0, 1'b0, 1'b1};
    lits[7] = '{-32768, -32768, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0};

    // Reset state, asserted from time 0.
    #2;
    check("rst_result",    result, 32'h0);
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_flags",     {29'b0, zero, negative, ovf16}, 32'h0);
    #10 rst_n = 1'b1;

    foreach (lits[i]) begin
      apply(lits[i].a, lits[i].b, lits[i].m);
      check($sformatf("lit%0d_result", i), result, lits[i].r);
      check($sformatf("lit%0d_model", i), m_res, lits[i].r);
      check($sformatf("lit%0d_out_valid", i), {31'b0, out_valid}, 32'h1);
      check($sformatf("lit%0d_flags", i), {29'b0, zero, negative, ovf16},
            {29'b0, lits[i].z, lits[i].n, lits[i].o});
    end

    // Idle cycle: out_valid drops, result and flags hold.
    @(negedge clk);
    in_valid = 1'b0;
    op1 = 16'sd1234;
    op2 = 16'sd99;
    @(posedge clk);
    #1;
    check("hold_out_valid", {31'b0, out_valid}, 32'h0);
    check("hold_result",    result, 32'h0);
    check("hold_zero",      {31'b0, zero}, 32'h1);

    // Asynchronous reset between edges while out_valid is high.
    apply(100, 23, MODE_ADD);
    check("pre_rst_result", result, 32'd123);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_result",    result, 32'h0);
    check("async_rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("async_rst_flags",     {29'b0, zero, negative, ovf16}, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_result",    result, 32'h0);
    check("post_rst_out_valid", {31'b0, out_valid}, 32'h0);

    // Random traffic, mostly back-to-back, checked by the per-cycle compare.
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      op1 = 16'($urandom);
      op2 = 16'($urandom);
      mode = 1'($urandom);
      in_valid = ($urandom_range(0, 4) != 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/adder_subtractor.md
Name: adder_subtractor

Overview:
- Registered 16-bit signed adder/subtractor producing a sign-extended 32-bit signed result plus status flags.
- Sits in the ALU datapath as the add/sub execution unit.
- Single-cycle latency with a simple valid pipeline flag.
- Built around a 17-bit ripple-carry core so that no 16-bit operation can wrap.

Parameters:
- WIDTH, 16, operand width in bits (signed two's complement).
- RES_WIDTH, 32, result width; must be >= WIDTH+1.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  op1/op2/mode are valid this cycle.
- op1  input  WIDTH  signed first operand.
- op2  input  WIDTH  signed second operand.
- mode  input  1  0 = add (op1+op2), 1 = subtract (op1-op2).
- result  output  RES_WIDTH  signed result, sign-extended.
- out_valid  output  1  result/flags correspond to an accepted input.
- zero  output  1  result == 0.
- negative  output  1  result < 0 (result MSB).
- ovf16  output  1  true result lies outside the signed WIDTH range [-32768, 32767].

Behaviour:
- Reset: while rst_n is low, result = 0, zero = 0, negative = 0, ovf16 = 0, out_valid = 0. Reset takes effect immediately, not at the next clock edge.
- Reset mid-operation discards any in-flight result. The first valid output after release needs a new in_valid.
- Arithmetic:
  - Sign-extend op1 and op2 to WIDTH+1 bits.
  - Add: sum = op1x + op2x.
  - Sub: sum = op1x + ~op2x + 1, i.e. invert op2x and carry-in = mode.
  - The 17-bit sum is always exact. Sign-extend it to RES_WIDTH for result.
- ovf16 = sum[WIDTH] XOR sum[WIDTH-1]. It flags that the exact result does not fit 16 bits; result itself remains exact.
- Timing: on a rising clk edge with in_valid = 1, register result and flags and set out_valid = 1. Latency is 1 cycle.
- Holding: on an edge with in_valid = 0, out_valid goes to 0 and result and flags hold their previous values.
- Back-to-back in_valid is accepted every cycle (throughput 1/cycle). There is no backpressure.
- Boundary cases (results in hex for RES_WIDTH = 32):
  - -32768 - 32767 = -65535 (0xFFFF0001), ovf16 = 1.
  - -32768 + -32768 = -65536 (0xFFFF0000), ovf16 = 1.
  - 32767 - (-32768) = 65535 (0x0000FFFF), ovf16 = 1.
- X or undefined mode while in_valid = 1 is illegal. Assertion: mode is known whenever in_valid = 1.

Decomposition:
- Shared package alu_pkg holds:
  - localparams MODE_ADD = 1'b0 and MODE_SUB = 1'b1;
  - ALU_OP_WIDTH = 16;
  - ALU_RES_WIDTH = 32;
  - a typedef for the signed operand and for the result.
- One sub-module, rca_adder: parameterised N-bit ripple-carry adder with inputs a, b and cin, outputs sum and cout. It is instantiated with N = WIDTH+1 and built from a generate loop of full-adder equations.
- The top level handles sign extension, operand inversion, flag logic and output registers.

Test Plan:
- Reset, then op1 = 5, op2 = 3, mode = 0, in_valid = 1 -> next cycle result = 8, out_valid = 1, zero = 0, negative = 0, ovf16 = 0.
- op1 = 3, op2 = 5, mode = 1 -> result = -2 (0xFFFFFFFE), negative = 1, ovf16 = 0.
- op1 = 32767, op2 = 1, mode = 0 -> result = 32768 (0x00008000), ovf16 = 1, negative = 0.
- op1 = -32768, op2 = 1, mode = 1 -> result = -32769 (0xFFFF7FFF), ovf16 = 1, negative = 1.
- op1 = -32768, op2 = -32768, mode = 1 -> result = 0, zero = 1; then in_valid = 0 -> out_valid = 0 and result holds 0.
- Drive rst_n low between clock edges while out_valid = 1 -> result = 0 and out_valid = 0 immediately. After release with in_valid = 0, outputs stay 0. Then 50 random op1/op2/mode vectors must match the 32-bit sign-extended op1 ± op2 reference.
